synthesizer_channel_gate: RTL

Per-channel enable/gain stage between the channelizer channel output and the synthesizer input, i.e. directly upstream of the synthesizer. It scales each channel's I/Q sample by a programmable unsigned fixed-point gain, or forces it to zero when the channel is disabled. Configuration is staged in a shadow table and committed atomically at a frame boundary (channel index 0), so the synthesizer never sees a half-updated frame. The sample cadence is preserved exactly: every input sample yields one output sample.

---
 rtl/synthesizer_channel_gate.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/synthesizer_channel_gate.sv
// Per-channel enable/gain stage feeding the synthesizer: shadow/active config tables
// committed at frame boundaries, plus a 2-cycle scale/round/saturate datapath.
module synthesizer_channel_gate #(
  parameter int unsigned NUM_CHANNELS        = 16,
  parameter int unsigned CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int unsigned DATA_WIDTH          = 20,
  parameter int unsigned GAIN_WIDTH          = 8,
  parameter int unsigned GAIN_FRAC_BITS      = 6
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                Cfg_valid,
  input  logic [CHANNEL_INDEX_WIDTH-1:0]      Cfg_channel,
  input  logic                                Cfg_enable,
  input  logic [GAIN_WIDTH-1:0]               Cfg_gain,
  input  logic                                Cfg_commit,
  input  logic                                Input_valid,
  input  logic [CHANNEL_INDEX_WIDTH-1:0]      Input_index,
  input  logic [1:0][DATA_WIDTH-1:0]          Input_data,
  output logic                                Output_valid,
  output logic [CHANNEL_INDEX_WIDTH-1:0]      Output_index,
  output logic [1:0][DATA_WIDTH-1:0]          Output_data,
  output logic                                Commit_pending,
  output logic                                Error_saturation,
  output logic                                Error_frame_order
);

  localparam int unsigned PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned RND_W  = SUM_W - GAIN_FRAC_BITS;

  localparam logic [GAIN_WIDTH-1:0]   UNITY   = GAIN_WIDTH'(1 << GAIN_FRAC_BITS);
  localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(1 << (GAIN_FRAC_BITS - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX =
    {{(RND_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN =
    {{(RND_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic [NUM_CHANNELS-1:0]                 sh_en_q, sh_en_d, ac_en_q, ac_en_d;
  logic [NUM_CHANNELS-1:0][GAIN_WIDTH-1:0] sh_gain_q, sh_gain_d, ac_gain_q, ac_gain_d;
  logic                                    pending_q, pending_d;
  logic                                    boundary_c;

  logic                                    v1_q, en1_q;
  logic [CHANNEL_INDEX_WIDTH-1:0]          idx1_q;
  logic [1:0][PROD_W-1:0]                  prod_q, prod_d;
  logic signed [PROD_W-1:0]                gain_s;

  logic signed [SUM_W-1:0]                 sum_c [2];
  logic signed [RND_W-1:0]                 rnd_c [2];
  logic [1:0]                              clip_c;
  logic [1:0][DATA_WIDTH-1:0]              sat_c;

  logic                                    out_valid_q, out_valid_d;
  logic [CHANNEL_INDEX_WIDTH-1:0]          out_index_q, out_index_d;
  logic [1:0][DATA_WIDTH-1:0]              out_data_q, out_data_d;
  logic                                    sat_err_q, sat_err_d;

  logic                                    synced_q, synced_d;
  logic [CHANNEL_INDEX_WIDTH-1:0]          expected_q, expected_d;
  logic                                    frame_err_q, frame_err_d;

  assign boundary_c = Input_valid && (Input_index == '0);

  // Copy reads the pre-write shadow, so a same-cycle write lands only in shadow.
  always_comb begin
    sh_en_d   = sh_en_q;
    sh_gain_d = sh_gain_q;
    ac_en_d   = ac_en_q;
    ac_gain_d = ac_gain_q;
    pending_d = pending_q;
    if (boundary_c && pending_q) begin
      ac_en_d   = sh_en_q;
      ac_gain_d = sh_gain_q;
      pending_d = 1'b0;
    end else if (Cfg_commit) begin
      pending_d = 1'b1;
    end
    if (Cfg_valid) begin
      sh_en_d[Cfg_channel]   = Cfg_enable;
      sh_gain_d[Cfg_channel] = Cfg_gain;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sh_en_q   <= '1;
      sh_gain_q <= {NUM_CHANNELS{UNITY}};
      ac_en_q   <= '1;
      ac_gain_q <= {NUM_CHANNELS{UNITY}};
      pending_q <= 1'b0;
    end else begin
      sh_en_q   <= sh_en_d;
      sh_gain_q <= sh_gain_d;
      ac_en_q   <= ac_en_d;
      ac_gain_q <= ac_gain_d;
      pending_q <= pending_d;
    end
  end

  // Stage 1 multiplies with the post-commit active entry (the index-0 sample sees new values).
  always_comb begin
    gain_s = PROD_W'($signed({1'b0, ac_gain_d[Input_index]}));
    for (int c = 0; c < 2; c++) begin
      prod_d[c] = PROD_W'($signed(Input_data[c])) * gain_s;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v1_q   <= 1'b0;
      en1_q  <= 1'b0;
      idx1_q <= '0;
      prod_q <= '0;
    end else begin
      v1_q   <= Input_valid;
      en1_q  <= ac_en_d[Input_index];
      idx1_q <= Input_index;
      prod_q <= prod_d;
    end
  end

  // Stage 2: round half up, then clip to the signed sample range.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sum_c[c]  = SUM_W'($signed(prod_q[c])) + ROUND;
      rnd_c[c]  = RND_W'(sum_c[c] >>> GAIN_FRAC_BITS);
      clip_c[c] = 1'b0;
      sat_c[c]  = rnd_c[c][DATA_WIDTH-1:0];
      if (rnd_c[c] > SAT_MAX) begin
        sat_c[c]  = SAT_MAX[DATA_WIDTH-1:0];
        clip_c[c] = 1'b1;
      end else if (rnd_c[c] < SAT_MIN) begin
        sat_c[c]  = SAT_MIN[DATA_WIDTH-1:0];
        clip_c[c] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = v1_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    sat_err_d   = 1'b0;
    if (v1_q) begin
      out_index_d = idx1_q;
      out_data_d  = en1_q ? sat_c : '0;
      sat_err_d   = en1_q && (|clip_c);
    end
  end

  // Frame tracker: first sample after reset only syncs; mismatches resync to index + 1.
  always_comb begin
    synced_d    = synced_q;
    expected_d  = expected_q;
    frame_err_d = 1'b0;
    if (Input_valid) begin
      frame_err_d = synced_q && (Input_index != expected_q);
      expected_d  = Input_index + CHANNEL_INDEX_WIDTH'(1);
      synced_d    = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      sat_err_q   <= 1'b0;
      synced_q    <= 1'b0;
      expected_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      sat_err_q   <= sat_err_d;
      synced_q    <= synced_d;
      expected_q  <= expected_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Output_valid      = out_valid_q;
  assign Output_index      = out_index_q;
  assign Output_data       = out_data_q;
  assign Commit_pending    = pending_q;
  assign Error_saturation  = sat_err_q;
  assign Error_frame_order = frame_err_q;

endmodule
